// File: rtl/usb_pkt_tx.sv
`timescale 1ns/1ps
// USB packet transmitter: serialises handshake (PID only) and data (PID, payload, CRC16) packets onto a UTMI byte bus.
// Latency: PID byte appears the cycle after acceptance; payload bytes pass straight through from pl_data to the UTM bus.
// Backpressure: every byte is held until utm_tx_ready; a payload byte is consumed only in the cycle the UTM takes it.

module usb_pkt_tx #(
    parameter int MAX_PKT = 64,
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    output logic       hs_ack,
    input  logic       data_req,
    input  logic [3:0] data_pid,
    input  logic       data_zlp,
    output logic       data_ack,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    input  logic       pl_last,
    output logic       pl_ready,
    output logic [7:0] utm_data_in,
    output logic       utm_tx_valid,
    input  logic       utm_tx_ready,
    output logic       pkt_done,
    output logic       tx_err,
    output logic       busy
);

    localparam int CW = $clog2(MAX_PKT + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_GAP
    } state_t;

    state_t          r_state;
    logic            r_is_hs;
    logic            r_zlp;
    logic [15:0]     r_crc;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap;
    logic [7:0]      r_tx_byte;
    logic            r_tx_valid;

    logic            w_in_data;
    logic            w_take;
    logic            w_cnt_full;
    logic            w_end_pay;
    logic            w_ovl;
    logic            w_under;
    logic            w_hs_acc;
    logic            w_dt_acc;
    logic [15:0]     w_crc_nxt;

    // Reflected CRC16 (poly 0x8005 -> 0xA001) advanced by one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {8'h00, d};
        for (int k = 0; k < 8; k++) begin
            x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
        end
        return x;
    endfunction

    // Payload handshake, end-of-payload and error conditions, and IDLE-only arbitration.
    always_comb begin
        w_in_data  = (r_state == S_DATA);
        w_take     = w_in_data & pl_valid & utm_tx_ready;
        w_cnt_full = (r_cnt == LAST_IDX);
        w_end_pay  = w_take & (pl_last | w_cnt_full);
        w_ovl      = w_take & ~pl_last & w_cnt_full;
        w_under    = w_in_data & ~pl_valid;
        w_hs_acc   = rst & (r_state == S_IDLE) & hs_req;
        w_dt_acc   = rst & (r_state == S_IDLE) & ~hs_req & data_req;
        w_crc_nxt  = crc16_byte(r_crc, pl_data);
    end

    // Output decode: payload passes through in DATA, otherwise the registered byte drives the bus.
    always_comb begin
        hs_ack       = w_hs_acc;
        data_ack     = w_dt_acc;
        pl_ready     = rst & w_take;
        utm_tx_valid = w_in_data ? pl_valid : r_tx_valid;
        utm_data_in  = w_in_data ? (pl_valid ? pl_data : 8'h00) : r_tx_byte;
        pkt_done     = rst & utm_tx_ready & r_tx_valid &
                       (((r_state == S_PID) & r_is_hs) | (r_state == S_CRC_HI));
        tx_err       = rst & (w_under | w_ovl);
        busy         = (r_state != S_IDLE);
    end

    // Packet sequencer: loads the next byte to present whenever the current one is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_is_hs    <= 1'b0;
            r_zlp      <= 1'b0;
            r_crc      <= 16'hFFFF;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_tx_byte  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs_acc) begin
                        r_is_hs    <= 1'b1;
                        r_zlp      <= 1'b0;
                        r_tx_byte  <= {~hs_pid, hs_pid};
                        r_tx_valid <= 1'b1;
                        r_crc      <= 16'hFFFF;
                        r_cnt      <= '0;
                        r_state    <= S_PID;
                    end else if (w_dt_acc) begin
                        r_is_hs    <= 1'b0;
                        r_zlp      <= data_zlp;
                        r_tx_byte  <= {~data_pid, data_pid};
                        r_tx_valid <= 1'b1;
                        r_crc      <= 16'hFFFF;
                        r_cnt      <= '0;
                        r_state    <= S_PID;
                    end
                end
                S_PID: begin
                    if (utm_tx_ready) begin
                        if (r_is_hs) begin
                            r_tx_byte  <= 8'h00;
                            r_tx_valid <= 1'b0;
                            r_gap      <= '0;
                            r_state    <= S_GAP;
                        end else if (r_zlp) begin
                            // Empty payload: CRC stays at its seed, so the complement is 0x0000.
                            r_tx_byte  <= ~r_crc[7:0];
                            r_tx_valid <= 1'b1;
                            r_state    <= S_CRC_LO;
                        end else begin
                            r_tx_byte  <= 8'h00;
                            r_tx_valid <= 1'b0;
                            r_state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_under) begin
                        // Source ran dry: drop tx_valid so the UTM truncates the packet.
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else if (w_take) begin
                        r_crc <= w_crc_nxt;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_end_pay) begin
                            r_tx_byte  <= ~w_crc_nxt[7:0];
                            r_tx_valid <= 1'b1;
                            r_state    <= S_CRC_LO;
                        end
                    end
                end
                S_CRC_LO: begin
                    if (utm_tx_ready) begin
                        r_tx_byte <= ~r_crc[15:8];
                        r_state   <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                    if (utm_tx_ready) begin
                        r_tx_byte  <= 8'h00;
                        r_tx_valid <= 1'b0;
                        r_gap      <= '0;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_END) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_tx_byte  <= 8'h00;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_pkt_tx.sv
`timescale 1ns/1ps
// Bench for usb_pkt_tx: directed and random packets against a queue-based model of the UTM byte stream.
// Latency: every accepted UTM byte is compared in the cycle it is taken.
// Backpressure: utm_tx_ready is either held high or toggled at random per cycle.

module tb_usb_pkt_tx;

    localparam int MAX_PKT = 64;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_req;
    logic [3:0] hs_pid;
    logic       hs_ack;
    logic       data_req;
    logic [3:0] data_pid;
    logic       data_zlp;
    logic       data_ack;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       pl_ready;
    logic [7:0] utm_data_in;
    logic       utm_tx_valid;
    logic       utm_tx_ready;
    logic       pkt_done;
    logic       tx_err;
    logic       busy;

    always #5 clk = ~clk;

    usb_pkt_tx #(.MAX_PKT(MAX_PKT), .GAP_CYC(GAP_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .hs_req       (hs_req),
        .hs_pid       (hs_pid),
        .hs_ack       (hs_ack),
        .data_req     (data_req),
        .data_pid     (data_pid),
        .data_zlp     (data_zlp),
        .data_ack     (data_ack),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_last      (pl_last),
        .pl_ready     (pl_ready),
        .utm_data_in  (utm_data_in),
        .utm_tx_valid (utm_tx_valid),
        .utm_tx_ready (utm_tx_ready),
        .pkt_done     (pkt_done),
        .tx_err       (tx_err),
        .busy         (busy)
    );

    typedef struct {
        logic [7:0] b;
        bit         last;
        bit         err;
        bit         pay;
    } exp_t;

    exp_t       q[$];
    logic [7:0] pay[0:127];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    bit         underrun_now = 1'b0;
    bit         rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
    endtask

    task automatic push(input logic [7:0] b, input bit last, input bit err, input bit p);
        exp_t e;
        e.b = b; e.last = last; e.err = err; e.pay = p;
        q.push_back(e);
    endtask

    // Bit-serial USB CRC16 over pay[0..len-1]; returns the transmitted (complemented) value.
    function automatic logic [15:0] model_crc(input int len);
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ pay[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic push_data_model(input logic [3:0] pid, input bit zlp, input int n,
                                   input bit has_last, input int uflow_at);
        int m;
        logic [15:0] c;
        push({~pid, pid}, 0, 0, 0);
        if (uflow_at >= 0 && !zlp) begin
            for (int i = 0; i < uflow_at; i++) push(pay[i], 0, 0, 1);
        end else begin
            m = zlp ? 0 : (has_last ? n : MAX_PKT);
            for (int i = 0; i < m; i++) push(pay[i], 0, (!has_last && i == MAX_PKT - 1), 1);
            c = model_crc(m);
            push(c[7:0], 0, 0, 0);
            push(c[15:8], 1, 0, 0);
        end
    endtask

    // Random or constant UTM readiness.
    initial begin
        utm_tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            utm_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: checks every accepted byte, pulses, hold behaviour and the gap after each packet.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    int         gap_cnt = 0;
    always @(negedge clk) begin : mon
        exp_t e;
        bit acc, e_done, e_err, e_pay;
        if (!rst) begin
            q.delete();
            prev_hold = 1'b0;
            gap_cnt = 0;
        end else begin
            acc = utm_tx_valid && utm_tx_ready;
            e_done = 0; e_err = underrun_now; e_pay = 0;
            if (acc) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_byte: got 0x%0h with nothing expected (cycle %0d)", utm_data_in, cyc);
                end else begin
                    e = q.pop_front();
                    check("utm_byte", utm_data_in, e.b);
                    e_done = e.last; e_err = e.err; e_pay = e.pay;
                end
            end
            if (acc || pkt_done) check("pkt_done", pkt_done, e_done);
            if (e_err || tx_err) check("tx_err", tx_err, e_err);
            if ((acc && e_pay) || pl_ready) check("pl_ready", pl_ready, acc && e_pay);
            if (prev_hold) begin
                check("hold_valid", utm_tx_valid, 1);
                check("hold_byte", utm_data_in, prev_byte);
            end
            if (!utm_tx_valid) check("idle_byte_zero", utm_data_in, 0);
            if (gap_cnt > 1) begin
                check("gap_busy", busy, 1);
                check("gap_valid", utm_tx_valid, 0);
            end else if (gap_cnt == 1) begin
                check("gap_then_idle", busy, 0);
            end
            if (gap_cnt > 0) gap_cnt--;
            if (pkt_done || (tx_err && !utm_tx_valid)) gap_cnt = GAP_CYC + 1;
            if (pkt_done) done_cyc = cyc;
            prev_hold = utm_tx_valid && !utm_tx_ready;
            prev_byte = utm_data_in;
        end
    end

    task automatic wait_ack(input bit hs, output int at);
        at = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (hs ? hs_ack : data_ack) begin
                at = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (at < 0) fail_now(hs ? "hs_ack_wait" : "data_ack_wait");
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail_now("packet_complete");
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic present(input int i, input int n, input bit has_last);
        if (i < n) begin
            pl_valid = 1'b1; pl_data = pay[i]; pl_last = has_last && (i == n - 1);
        end else begin
            pl_valid = 1'b0; pl_data = 8'h00; pl_last = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'h00;
        hs_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        check("rst_cycle_tx_err", tx_err, 0);
        check("rst_cycle_pkt_done", pkt_done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", utm_tx_valid, 0);
        check("rst_data_in", utm_data_in, 0);
        check("rst_pl_ready", pl_ready, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_hs_ack", hs_ack, 0);
        check("rst_data_ack", data_ack, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_hs(input logic [3:0] pid, input logic [7:0] exp_b, output int ack_at);
        push(exp_b, 1, 0, 0);
        hs_pid = pid; hs_req = 1'b1;
        wait_ack(1, ack_at);
        @(posedge clk);
        @(negedge clk);
        check("hs_ack_one_pulse", hs_ack, 0);
        @(posedge clk); #1;
        hs_req = 1'b0;
        wait_done();
    endtask

    task automatic run_data(input logic [3:0] pid, input bit zlp, input int n, input bit has_last,
                            input int uflow_at, input int rst_at, input bit pre);
        int m, i, a;
        bit abort, hung;
        m = zlp ? 0 : ((has_last || uflow_at >= 0 || rst_at >= 0) ? n : MAX_PKT);
        if (!pre) push_data_model(pid, zlp, n, has_last, uflow_at);
        data_pid = pid; data_zlp = zlp; data_req = 1'b1;
        if (zlp) present(0, 0, 0); else present(0, n, has_last);
        wait_ack(0, a);
        @(posedge clk); #1;
        data_req = 1'b0;
        i = 0; abort = 0; hung = 1;
        for (int t = 0; t < 4000; t++) begin
            if (i >= m || abort) begin
                hung = 0;
                break;
            end
            @(negedge clk);
            if (pl_ready) i++;
            @(posedge clk); #1;
            if (uflow_at >= 0 && i == uflow_at) begin
                pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'h00; underrun_now = 1'b1;
                @(negedge clk);
                check("underrun_valid_low", utm_tx_valid, 0);
                @(posedge clk); #1;
                underrun_now = 1'b0;
                abort = 1;
            end else if (rst_at >= 0 && i == rst_at) begin
                do_reset();
                abort = 1;
            end else begin
                present(i, n, has_last);
            end
        end
        if (hung) fail_now("payload_consume");
        if (!(abort && rst_at >= 0)) wait_done();
        pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'h00;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a, b, n, k;
        logic [3:0] p;
        string s;
        logic [3:0] hs_pids[3];
        hs_pids[0] = 4'h2; hs_pids[1] = 4'hA; hs_pids[2] = 4'hE;

        rst = 1'b0; hs_req = 1'b0; hs_pid = 4'h0; data_req = 1'b0; data_pid = 4'h0;
        data_zlp = 1'b0; pl_data = 8'h00; pl_valid = 1'b0; pl_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("init_busy", busy, 0);
        check("init_tx_valid", utm_tx_valid, 0);
        check("init_data_in", utm_data_in, 0);
        check("init_pl_ready", pl_ready, 0);
        check("init_pkt_done", pkt_done, 0);
        check("init_tx_err", tx_err, 0);
        @(posedge clk); #1;

        // Model pin: CRC-16/USB check value for "123456789".
        s = "123456789";
        for (int i = 0; i < 9; i++) pay[i] = s[i];
        check("model_crc_check", model_crc(9), 16'hB4C8);

        // ACK handshake with the UTM always ready.
        rdy_rand = 1'b0;
        run_hs(4'h2, 8'hD2, a);
        check("hs_ack_to_done", done_cyc - a, 1);

        // Handshake and data requested together: handshake wins, data waits for the gap.
        push(8'h5A, 1, 0, 0); push(8'hC3, 0, 0, 0); push(8'h00, 0, 0, 0); push(8'h00, 1, 0, 0);
        hs_pid = 4'hA; hs_req = 1'b1; data_pid = 4'h3; data_zlp = 1'b1; data_req = 1'b1;
        wait_ack(1, a);
        check("data_ack_blocked", data_ack, 0);
        @(posedge clk); #1;
        hs_req = 1'b0;
        wait_ack(0, b);
        check("data_ack_after_gap", b - done_cyc, GAP_CYC + 1);
        @(posedge clk); #1;
        data_req = 1'b0;
        wait_done();

        // DATA0 zero-length packet, literal bytes.
        push(8'hC3, 0, 0, 0); push(8'h00, 0, 0, 0); push(8'h00, 1, 0, 0);
        run_data(4'h3, 1, 0, 1, -1, -1, 1);

        // DATA0 carrying "123456789": literal CRC bytes.
        push(8'hC3, 0, 0, 0);
        for (int i = 0; i < 9; i++) push(pay[i], 0, 0, 1);
        push(8'hC8, 0, 0, 0); push(8'hB4, 1, 0, 0);
        run_data(4'h3, 0, 9, 1, -1, -1, 1);

        // DATA1 with payload 00..03 and random UTM readiness.
        rdy_rand = 1'b1;
        for (int i = 0; i < 4; i++) pay[i] = 8'(i);
        run_data(4'hB, 0, 4, 1, -1, -1, 0);

        // Underrun after two payload bytes.
        for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
        run_data(4'h3, 0, 6, 1, 2, -1, 0);

        // 65-byte stream without pl_last: byte 64 closes the packet with tx_err.
        for (int i = 0; i < 65; i++) pay[i] = 8'(i + 8'h40);
        run_data(4'h3, 0, 65, 0, -1, -1, 0);

        // Reset in the middle of the payload, then a normal request.
        for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
        run_data(4'hB, 0, 20, 1, -1, 5, 0);
        run_hs(4'hE, 8'h1E, a);

        // Random traffic.
        for (int r = 0; r < 25; r++) begin
            rdy_rand = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 2);
            if (k == 0) begin
                p = hs_pids[$urandom_range(0, 2)];
                run_hs(p, {~p, p}, a);
            end else begin
                p = ($urandom_range(0, 1) == 1) ? 4'hB : 4'h3;
                n = $urandom_range(1, MAX_PKT);
                for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
                run_data(p, ($urandom_range(0, 3) == 0), n, 1, -1, -1, 0);
            end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
